// File: rtl/msft_dv_ip_bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding and
// byte-enable to bit-mask expansion.
package msft_dv_ip_bram_arb_pkg;

    typedef enum logic [0:0] {
        ISSUE,
        RMW_WR
    } state_e;

    // Upper bound on byte lanes; widths beyond MAX_BW*8 bits are rejected at elaboration.
    localparam int unsigned MAX_BW = 64;

    function automatic logic [MAX_BW*8-1:0] be2mask(input logic [MAX_BW-1:0] be);
        logic [MAX_BW*8-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BW; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/msft_dv_ip_bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter; master = requesters, slave = arbiter.
interface msft_dv_ip_bram_port_arbiter_if #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned RAM_DEPTH = 1024
);
    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned BW = RAM_WIDTH / 8;

    logic [NUM_REQ-1:0]           req_i;
    logic [NUM_REQ-1:0]           we_i;
    logic [NUM_REQ*BW-1:0]        be_i;
    logic [NUM_REQ*AW-1:0]        addr_i;
    logic [NUM_REQ*RAM_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]           gnt_o;
    logic [NUM_REQ-1:0]           rvalid_o;
    logic [RAM_WIDTH-1:0]         rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/msft_dv_ip_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above i_ptr, with wrap.
module msft_dv_ip_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_gnt
);

    localparam int unsigned IW1 = IW + 1;

    logic           w_found;
    logic [IW1-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, i_ptr} + IW1'(i);
            if (w_idx >= IW1'(NUM_REQ)) begin
                w_idx = w_idx - IW1'(NUM_REQ);
            end
            if (i_enable && !w_found && i_req[w_idx[IW-1:0]]) begin
                o_gnt[w_idx[IW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msft_dv_ip_bram_port_arbiter.sv
// Round-robin sharing of one single-port BRAM between NUM_REQ requesters; partial-byte
// writes are turned into a read-modify-write because the RAM has no byte enables.
module msft_dv_ip_bram_port_arbiter
    import msft_dv_ip_bram_arb_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned NUM_REQ   = 2,
    localparam int unsigned AW       = $clog2(RAM_DEPTH),
    localparam int unsigned BW       = RAM_WIDTH / 8,
    localparam int unsigned IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    msft_dv_ip_bram_port_arbiter_if.slave bus,
    output logic                 ram_cs_o,
    output logic                 ram_we_o,
    output logic [AW-1:0]        ram_addr_o,
    output logic [RAM_WIDTH-1:0] ram_din_o,
    input  logic [RAM_WIDTH-1:0] ram_dout_i
);

    if ((RAM_WIDTH % 8 != 0) || (RAM_WIDTH > MAX_BW * 8)) begin : g_bad_width
        $error("RAM_WIDTH must be a multiple of 8 and at most %0d", MAX_BW * 8);
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be at least 2");
    end

    state_e               r_state;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        r_id;
    logic [AW-1:0]        r_addr;
    logic [RAM_WIDTH-1:0] r_wdata;
    logic [BW-1:0]        r_be;
    logic [NUM_REQ-1:0]   r_rvalid;

    logic                 w_enable;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_any;
    logic [IW-1:0]        w_win;
    logic [IW-1:0]        w_next_ptr;
    logic                 w_we;
    logic [BW-1:0]        w_be;
    logic [AW-1:0]        w_addr;
    logic [RAM_WIDTH-1:0] w_wdata;
    logic                 w_full;
    logic                 w_none;
    logic                 w_partial;
    logic [RAM_WIDTH-1:0] w_mask;
    logic [RAM_WIDTH-1:0] w_merge;

    assign w_enable = rstn && (r_state == ISSUE);

    msft_dv_ip_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (bus.req_i),
        .i_ptr   (r_rr_ptr),
        .i_enable(w_enable),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_win   = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win   = IW'(i);
                w_we    = bus.we_i[i];
                w_be    = bus.be_i[i*BW +: BW];
                w_addr  = bus.addr_i[i*AW +: AW];
                w_wdata = bus.wdata_i[i*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    assign w_any      = |w_gnt;
    assign w_full     = &w_be;
    assign w_none     = ~|w_be;
    assign w_partial  = w_we && !w_full && !w_none;
    assign w_next_ptr = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_mask     = RAM_WIDTH'(be2mask(MAX_BW'(r_be)));
    assign w_merge    = (ram_dout_i & ~w_mask) | (r_wdata & w_mask);

    // RAM controls are Mealy so the access lands in the same cycle as the grant.
    always_comb begin
        ram_cs_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = w_addr;
        ram_din_o  = w_wdata;
        if (r_state == RMW_WR) begin
            ram_cs_o   = rstn;
            ram_we_o   = rstn;
            ram_addr_o = r_addr;
            ram_din_o  = w_merge;
        end else if (w_any) begin
            ram_cs_o = !(w_we && w_none);
            ram_we_o = w_we && w_full;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ISSUE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                ISSUE: begin
                    if (w_any) begin
                        r_rr_ptr <= w_next_ptr;
                        if (w_partial) begin
                            r_id    <= w_win;
                            r_addr  <= w_addr;
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                            r_state <= RMW_WR;
                        end else begin
                            r_rvalid <= w_gnt;
                        end
                    end
                end
                RMW_WR: begin
                    r_rvalid[r_id] <= 1'b1;
                    r_state        <= ISSUE;
                end
            endcase
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_msft_dv_ip_bram_port_arbiter.sv
// Directed bench for the BRAM port arbiter with a behavioural single-port RAM model.
module tb_msft_dv_ip_bram_port_arbiter;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned RAM_WIDTH = 32;
    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned AW        = 10;

    logic                 clk;
    logic                 rstn;
    logic                 ram_cs;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [RAM_WIDTH-1:0] ram_din;
    logic [RAM_WIDTH-1:0] ram_dout;

    logic [RAM_WIDTH-1:0] mem     [RAM_DEPTH];
    logic                 mem_vld [RAM_DEPTH];

    int checks;
    int errors;

    msft_dv_ip_bram_port_arbiter_if #(
        .NUM_REQ  (NUM_REQ),
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH)
    ) bus ();

    msft_dv_ip_bram_port_arbiter #(
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH),
        .NUM_REQ  (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .ram_cs_o  (ram_cs),
        .ram_we_o  (ram_we),
        .ram_addr_o(ram_addr),
        .ram_din_o (ram_din),
        .ram_dout_i(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on contents of the words the bench reads before writing them.
    function automatic logic [RAM_WIDTH-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            10'd0:   return 32'hA0A0_A0A0;
            10'd1:   return 32'hB1B1_B1B1;
            10'd3:   return 32'h3333_3333;
            10'd7:   return 32'h1122_3344;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_din;
                mem_vld[ram_addr] <= 1'b1;
            end else begin
                ram_dout <= mem_vld[ram_addr] ? mem[ram_addr] : init_word(ram_addr);
            end
        end
    end

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            mem_vld[i] = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic req, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
        bus.req_i[r]          = req;
        bus.we_i[r]           = we;
        bus.be_i[r*4 +: 4]    = be;
        bus.addr_i[r*AW +: AW] = addr;
        bus.wdata_i[r*32 +: 32] = wdata;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        ram_dout = '0;
        rstn     = 1'b0;
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.be_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;

        // Reset with both requesting.
        drive(0, 1'b1, 1'b0, 4'hF, 10'd0, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 10'd1, 32'h0);
        #2;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_cs", 32'(ram_cs), 32'd0);
        tick();
        tick();
        chk("rst_gnt_hold", 32'(bus.gnt_o), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        rstn = 1'b1;
        #1;

        // Contention: alternate 0,1,0,1,0,1 with rvalid one cycle behind.
        for (int k = 0; k < 6; k++) begin
            chk("cont_gnt", 32'(bus.gnt_o), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk("cont_addr", 32'(ram_addr), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk("cont_rvalid", 32'(bus.rvalid_o), (k % 2 == 1) ? 32'd1 : 32'd2);
                chk("cont_rdata", bus.rdata_o, (k % 2 == 1) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
            end
            tick();
        end
        drive(0, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        #1;
        chk("cont_last_rvalid", 32'(bus.rvalid_o), 32'd2);
        chk("cont_last_rdata", bus.rdata_o, 32'hB1B1_B1B1);
        chk("cont_idle_gnt", 32'(bus.gnt_o), 32'd0);

        // Full write then read-back from the other port.
        drive(0, 1'b1, 1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF);
        #1;
        chk("fw_gnt", 32'(bus.gnt_o), 32'd1);
        chk("fw_cs", 32'(ram_cs), 32'd1);
        chk("fw_we", 32'(ram_we), 32'd1);
        chk("fw_addr", 32'(ram_addr), 32'd5);
        chk("fw_din", ram_din, 32'hDEAD_BEEF);
        tick();
        drive(0, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
        #1;
        chk("fw_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("rd_gnt", 32'(bus.gnt_o), 32'd2);
        tick();
        drive(1, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        #1;
        chk("rd_rvalid", 32'(bus.rvalid_o), 32'd2);
        chk("rd_rdata", bus.rdata_o, 32'hDEAD_BEEF);

        // Partial write becomes RMW; req0 asks during RMW_WR and must wait.
        drive(1, 1'b1, 1'b1, 4'b0101, 10'd7, 32'hAABB_CCDD);
        #1;
        chk("rmw_gnt", 32'(bus.gnt_o), 32'd2);
        chk("rmw_cs", 32'(ram_cs), 32'd1);
        chk("rmw_we_rd", 32'(ram_we), 32'd0);
        chk("rmw_addr", 32'(ram_addr), 32'd7);
        tick();
        drive(1, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        drive(0, 1'b1, 1'b0, 4'hF, 10'd7, 32'h0);
        #1;
        chk("rmw_no_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rmw_we_wr", 32'(ram_we), 32'd1);
        chk("rmw_addr_wr", 32'(ram_addr), 32'd7);
        chk("rmw_din", ram_din, 32'h11BB_33DD);
        chk("rmw_rvalid_early", 32'(bus.rvalid_o), 32'd0);
        tick();
        chk("rmw_rvalid", 32'(bus.rvalid_o), 32'd2);
        chk("rmw_next_gnt", 32'(bus.gnt_o), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        #1;
        chk("rmw_rb_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("rmw_rb_rdata", bus.rdata_o, 32'h11BB_33DD);

        // Write with no byte enables touches nothing.
        drive(0, 1'b1, 1'b1, 4'h0, 10'd3, 32'hFFFF_FFFF);
        #1;
        chk("be0_gnt", 32'(bus.gnt_o), 32'd1);
        chk("be0_cs", 32'(ram_cs), 32'd0);
        tick();
        drive(0, 1'b1, 1'b0, 4'hF, 10'd3, 32'h0);
        #1;
        chk("be0_rvalid", 32'(bus.rvalid_o), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        #1;
        chk("be0_rb_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("be0_rb_rdata", bus.rdata_o, 32'h3333_3333);

        // Reset lands during RMW_WR: merge write and rvalid are dropped.
        drive(1, 1'b1, 1'b1, 4'b0001, 10'd7, 32'h0000_0000);
        #1;
        chk("mr_gnt", 32'(bus.gnt_o), 32'd2);
        chk("mr_we_rd", 32'(ram_we), 32'd0);
        tick();
        drive(1, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("mr_cs", 32'(ram_cs), 32'd0);
        chk("mr_we", 32'(ram_we), 32'd0);
        chk("mr_rvalid", 32'(bus.rvalid_o), 32'd0);
        tick();
        chk("mr_rvalid_hold", 32'(bus.rvalid_o), 32'd0);
        rstn = 1'b1;
        drive(0, 1'b1, 1'b0, 4'hF, 10'd7, 32'h0);
        #1;
        chk("mr_rb_gnt", 32'(bus.gnt_o), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 4'hF, 10'd0, 32'h0);
        #1;
        chk("mr_rb_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("mr_rb_rdata", bus.rdata_o, 32'h11BB_33DD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
